video_scanout: RTL and testbench
================================

Name: video_scanout

Overview:
Parametrised raster scan-out engine. Generates VGA-class timing from one system clock. Fetches frame-buffer bytes over a ready-qualified read port and drives an 8-bit RGB332 pixel bus, with aligned sync and data-enable outputs.
Generalises the fixed 640x480 output block with:
- configurable timing, pixel-clock divide and pixel replication
- three pixel modes (8bpp direct, 4bpp and 2bpp through a writable palette)
- fetch-underflow detection and frame/line event outputs

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (>=1)
REPL_SHIFT, 1, log2 of pixel/line replication (0..2)
STRIDE, 512, frame-buffer bytes per logical line
ADDR_WIDTH, 17, frame-buffer address width
SYNC_ACTIVE_HIGH, 0, 0 = active-low syncs, 1 = active-high

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode  in  2  0 = 8bpp direct, 1 = 4bpp palette, 2 = 2bpp palette, 3 = forced black
videoAddress  out  ADDR_WIDTH  frame-buffer byte address
videoData  in  8  frame-buffer read data
videoDataReady  in  1  videoData valid this clock
paletteWe  in  1  palette write strobe
paletteIndex  in  4  palette entry to write
paletteData  in  8  RGB332 value to write
underflowClear  in  1  clears underflow
lineCompare  in  10  line number for lineIrq
videoOutput  out  8  RGB332 pixel
videoActive  out  1  data enable, aligned with videoOutput
hSync  out  1  horizontal sync
vSync  out  1  vertical sync
frameStart  out  1  one-clock pulse at frame origin
lineIrq  out  1  one-clock pulse at start of line lineCompare
underflow  out  1  sticky fetch-miss flag

Behaviour:
Reset is asynchronous and active-high. Reset values:
- divider, xAddr and yAddr = 0
- videoOutput = 0, videoActive = 0
- hSync and vSync inactive (1 when SYNC_ACTIVE_HIGH = 0)
- frameStart, lineIrq and underflow = 0
- palette = default 16-entry table; data latch = 0; active mode = 0

Pixel enable:
- Asserted for one clock every CLK_DIV clocks; divider counts 0..CLK_DIV-1.
- With CLK_DIV = 1, enable is constantly high.

Counters advance on pixel enable only:
- xAddr wraps at HT-1, where HT = sum of the H parameters.
- yAddr increments on x wrap and wraps at VT-1, where VT = sum of the V parameters.

Address generation (combinational from counters):
- lx = xAddr >> REPL_SHIFT
- ly = yAddr >> REPL_SHIFT
- videoAddress = ly*STRIDE + (lx >> P), where P = 0/1/2 for mode 0/1/2
- The address is a don't-care outside the visible area.

Data latch:
- Captures videoData on any clock where videoDataReady = 1.
- A fetch is pending from each address change until the next ready.
- If a visible pixel is emitted with a fetch still pending:
  - the stale latch is used
  - underflow sets and stays set until underflowClear
  - if set and clear coincide, set wins

Pixel select:
- Mode 1: high nibble first (lx[0] = 0 selects [7:4]).
- Mode 2: pairs [7:6], [5:4], [3:2], [1:0] selected by lx[1:0]. The 2-bit value indexes palette entries 0..3.

Output stage:
- One register stage, updated on pixel enable: the output for counter (x,y) appears one pixel period later.
- hSync, vSync and videoActive are registered in the same stage so all outputs stay aligned.
- Outside the visible area: videoOutput = 0, videoActive = 0. The output is never tristated.
- hSync is active for x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; vSync uses the analogous y range.

Mode sampling:
- mode is sampled into the active mode only on the pixel enable where the counters wrap to (0,0).
- Mid-frame mode changes never tear the picture.

Palette:
- A write takes effect on the following clock.
- A same-clock read of the entry being written returns the old value.

frameStart:
- One-clock pulse coincident with the pixel enable that wraps the counters to (0,0).

Optional Feature:
Macro VIDEO_LINE_IRQ_EN.
- Defined: lineIrq pulses for one clock on the pixel enable where xAddr wraps to 0 and the new yAddr equals lineCompare. Values >= VT never fire.
- Undefined: lineIrq is tied 0 and lineCompare is ignored. Ports remain present.

Decomposition:
Package video_pkg holds:
- mode enum: MODE_DIRECT, MODE_PAL4, MODE_PAL2, MODE_BLANK
- RGB332 typedef
- DEFAULT_PALETTE constant: 00,80,30,B0,06,86,1E,A4,52,DB,7B,FB,5F,DF,7F,FF

One sub-module, video_palette: 16x8 register file with async reset to DEFAULT_PALETTE, one write port and one combinational read port.

Test Plan:
- Defaults, videoDataReady held 1 -> hSync low for x = 656..751; vSync low for y = 490..491; frameStart period 840000 clocks.
- Mode 0, videoData = 8'h5A on every fetch -> videoOutput = 8'h5A with videoActive = 1 for 640 pixels per line; 0 in blanking.
- Mode 1, videoData = 8'h1F -> pixel pairs alternate 8'h80 then 8'hFF. Write palette[1] = 8'hE0 -> following pixels 8'hE0 then 8'hFF.
- Mode changed 0→2 mid-frame -> output stays direct until frameStart, then 2bpp (byte 8'h1B yields entries 0,1,2,3).
- videoDataReady held 0 after reset -> underflow = 1 at first visible pixel; stays 1 until underflowClear pulse; re-sets on next miss.
- VIDEO_LINE_IRQ_EN defined, lineCompare = 100 -> exactly one lineIrq per frame, at x wrap into y = 100. Reset asserted mid-line -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video_scanout raster engine.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_PAL4   = 2'd1,
        MODE_PAL2   = 2'd2,
        MODE_BLANK  = 2'd3
    } video_mode_e;

    typedef logic [7:0] rgb332_t;

    // Entry i lives in bits [8*i +: 8].
    localparam logic [127:0] DEFAULT_PALETTE = {
        8'hFF, 8'h7F, 8'hDF, 8'h5F, 8'hFB, 8'h7B, 8'hDB, 8'h52,
        8'hA4, 8'h1E, 8'h86, 8'h06, 8'hB0, 8'h30, 8'h80, 8'h00
    };

    function automatic rgb332_t default_entry(input logic [3:0] idx);
        return DEFAULT_PALETTE[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/video_palette.sv
// 16 x RGB332 palette: one write port, one combinational read port.
// Reads return the stored value, so a same-clock write is seen one clock later.
module video_palette
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] wr_index,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_index,
    output logic [7:0] rd_data
);

    rgb332_t mem_q [16];
    rgb332_t mem_d [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[wr_index] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= default_entry(4'(i));
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data = mem_q[rd_index];

endmodule

// File: rtl/video_scanout.sv
// Raster scan-out: timing counters, frame-buffer fetch, palette lookup, aligned output stage.
// Optional line interrupt is built when VIDEO_LINE_IRQ_EN is defined.
module video_scanout
    import video_pkg::*;
#(
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int CLK_DIV          = 2,
    parameter int REPL_SHIFT       = 1,
    parameter int STRIDE           = 512,
    parameter int ADDR_WIDTH       = 17,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] videoAddress,
    input  logic [7:0]            videoData,
    input  logic                  videoDataReady,
    input  logic                  paletteWe,
    input  logic [3:0]            paletteIndex,
    input  logic [7:0]            paletteData,
    input  logic                  underflowClear,
    input  logic [9:0]            lineCompare,
    output logic [7:0]            videoOutput,
    output logic                  videoActive,
    output logic                  hSync,
    output logic                  vSync,
    output logic                  frameStart,
    output logic                  lineIrq,
    output logic                  underflow
);

    localparam int HT       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT       = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW       = $clog2(HT);
    localparam int YW       = $clog2(VT);
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    logic [DW-1:0]         div_q, div_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    video_mode_e           mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  pend_q, pend_d;
    logic [7:0]            data_q, data_d;
    logic                  und_q, und_d;
    logic [7:0]            pix_q, pix_d;
    logic                  act_q, act_d;
    logic                  hs_q, hs_d;
    logic                  vs_q, vs_d;

    logic          pix_en, x_wrap, last_line, frame_wrap, visible;
    logic          fetch_wait, miss, in_hs, in_vs;
    logic [XW-1:0] lx, lx_word;
    logic [YW-1:0] ly;
    logic [7:0]    byte_now, pix_sel, pal_rd;
    logic [3:0]    nib, pal_idx;
    logic [1:0]    crumb;

    video_palette u_palette (
        .clk      (clock),
        .rst      (reset),
        .we       (paletteWe),
        .wr_index (paletteIndex),
        .wr_data  (paletteData),
        .rd_index (pal_idx),
        .rd_data  (pal_rd)
    );

    always_comb begin
        pix_en     = (div_q == DW'(CLK_DIV - 1));
        div_d      = pix_en ? '0 : div_q + DW'(1);
        x_wrap     = (int'(x_q) == HT - 1);
        last_line  = (int'(y_q) == VT - 1);
        frame_wrap = pix_en & x_wrap & last_line;
        visible    = (int'(x_q) < H_VISIBLE) && (int'(y_q) < V_VISIBLE);
        in_hs      = (int'(x_q) >= HS_START) && (int'(x_q) <= HS_END);
        in_vs      = (int'(y_q) >= VS_START) && (int'(y_q) <= VS_END);

        x_d    = x_q;
        y_d    = y_q;
        mode_d = mode_q;
        if (pix_en) begin
            x_d = x_wrap ? '0 : x_q + XW'(1);
            if (x_wrap) begin
                y_d = last_line ? '0 : y_q + YW'(1);
            end
            // Mode only changes at the frame origin so a frame is never mixed.
            if (frame_wrap) begin
                mode_d = video_mode_e'(mode);
            end
        end

        lx = x_q >> REPL_SHIFT;
        ly = y_q >> REPL_SHIFT;
        case (mode_q)
            MODE_PAL4: lx_word = lx >> 1;
            MODE_PAL2: lx_word = lx >> 2;
            default:   lx_word = lx;
        endcase
        addr_d = ADDR_WIDTH'(ly) * ADDR_WIDTH'(STRIDE) + ADDR_WIDTH'(lx_word);

        // A new address owes a fetch until the port reports ready data.
        fetch_wait = pend_q | (addr_d != addr_q);
        pend_d     = fetch_wait & ~videoDataReady;
        data_d     = videoDataReady ? videoData : data_q;
        byte_now   = videoDataReady ? videoData : data_q;
        miss       = pix_en & visible & fetch_wait & ~videoDataReady;
        und_d      = miss | (und_q & ~underflowClear);

        nib = lx[0] ? byte_now[3:0] : byte_now[7:4];
        case (lx[1:0])
            2'd0:    crumb = byte_now[7:6];
            2'd1:    crumb = byte_now[5:4];
            2'd2:    crumb = byte_now[3:2];
            default: crumb = byte_now[1:0];
        endcase
        pal_idx = (mode_q == MODE_PAL2) ? {2'b00, crumb} : nib;
        case (mode_q)
            MODE_DIRECT: pix_sel = byte_now;
            MODE_PAL4:   pix_sel = pal_rd;
            MODE_PAL2:   pix_sel = pal_rd;
            default:     pix_sel = 8'h00;
        endcase

        pix_d = pix_q;
        act_d = act_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_en) begin
            pix_d = visible ? pix_sel : 8'h00;
            act_d = visible;
            hs_d  = in_hs ? SYNC_ON : ~SYNC_ON;
            vs_d  = in_vs ? SYNC_ON : ~SYNC_ON;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= MODE_DIRECT;
            addr_q <= '0;
            pend_q <= 1'b1;
            data_q <= 8'h00;
            und_q  <= 1'b0;
            pix_q  <= 8'h00;
            act_q  <= 1'b0;
            hs_q   <= ~SYNC_ON;
            vs_q   <= ~SYNC_ON;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            mode_q <= mode_d;
            addr_q <= addr_d;
            pend_q <= pend_d;
            data_q <= data_d;
            und_q  <= und_d;
            pix_q  <= pix_d;
            act_q  <= act_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
        end
    end

    assign videoAddress = addr_d;
    assign videoOutput  = pix_q;
    assign videoActive  = act_q;
    assign hSync        = hs_q;
    assign vSync        = vs_q;
    assign underflow    = und_q;
    assign frameStart   = frame_wrap;

`ifdef VIDEO_LINE_IRQ_EN
    assign lineIrq = pix_en & x_wrap & (int'(y_d) == int'(lineCompare));
`else
    logic unused_line_compare;
    assign unused_line_compare = ^lineCompare;
    assign lineIrq = 1'b0;
`endif

endmodule

// File: tb/tb_video_scanout.sv
// Randomized bench for video_scanout on a shrunken raster, checked against a pixel-level model.
module tb_video_scanout;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8, VF = 1, VS = 2, VB = 1;
    localparam int CD = 2, RS = 1, ST = 16, AW = 17;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic [AW-1:0] videoAddress;
    logic [7:0]    videoData;
    logic          videoDataReady;
    logic          paletteWe;
    logic [3:0]    paletteIndex;
    logic [7:0]    paletteData;
    logic          underflowClear;
    logic [9:0]    lineCompare;
    logic [7:0]    videoOutput;
    logic          videoActive, hSync, vSync, frameStart, lineIrq, underflow;

    video_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(CD), .REPL_SHIFT(RS), .STRIDE(ST), .ADDR_WIDTH(AW),
        .SYNC_ACTIVE_HIGH(0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mode           (mode),
        .videoAddress   (videoAddress),
        .videoData      (videoData),
        .videoDataReady (videoDataReady),
        .paletteWe      (paletteWe),
        .paletteIndex   (paletteIndex),
        .paletteData    (paletteData),
        .underflowClear (underflowClear),
        .lineCompare    (lineCompare),
        .videoOutput    (videoOutput),
        .videoActive    (videoActive),
        .hSync          (hSync),
        .vSync          (vSync),
        .frameStart     (frameStart),
        .lineIrq        (lineIrq),
        .underflow      (underflow)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Frame-buffer memory answering the read port
    logic [7:0] fb [256];
    assign videoData = fb[videoAddress[7:0]];

    // Reference model state
    logic [7:0]  pal [16];
    logic [10:0] exp_q [$];
    logic [7:0]  exp_pix;
    logic        exp_act, exp_hs, exp_vs;
    int          edge_n;
    int          cur_mode;
    int          cyc;
    int          next_mode_at, next_lc_at;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        logic [7:0] def [16];
        def = '{8'h00, 8'h80, 8'h30, 8'hB0, 8'h06, 8'h86, 8'h1E, 8'hA4,
                8'h52, 8'hDB, 8'h7B, 8'hFB, 8'h5F, 8'hDF, 8'h7F, 8'hFF};
        for (int i = 0; i < 16; i++) pal[i] = def[i];
        edge_n   = 0;
        cur_mode = 0;
        exp_pix  = 8'h00;
        exp_act  = 1'b0;
        exp_hs   = 1'b1;
        exp_vs   = 1'b1;
        exp_q.delete();
    endtask

    // Colour of raster pixel (x,y) from the frame buffer, palette and display mode.
    function automatic logic [7:0] model_pixel(input int x, input int y, input int md);
        int lx, ly, per_byte, b, v;
        if (x >= HV || y >= VV || md == 3) return 8'h00;
        lx = x / (1 << RS);
        ly = y / (1 << RS);
        per_byte = (md == 0) ? 1 : ((md == 1) ? 2 : 4);
        b = int'(fb[(ly * ST + lx / per_byte) % 256]);
        if (md == 0) return 8'(b);
        if (md == 1) v = (lx % 2 == 0) ? b / 16 : b % 16;
        else         v = (b >> (6 - 2 * (lx % 4))) % 4;
        return pal[v];
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int p, pos, x, y;
        logic act, hs, vs;
        edge_n++;
        if (edge_n % CD == 0) begin
            p   = edge_n / CD - 1;
            pos = p % FRAME;
            x   = pos % HT;
            y   = pos / HT;
            act = (x < HV) && (y < VV);
            hs  = !((x >= HV + HF) && (x < HV + HF + HS));
            vs  = !((y >= VV + VF) && (y < VV + VF + VS));
            exp_q.push_back({act, hs, vs, model_pixel(x, y, cur_mode)});
            if (pos == FRAME - 1) cur_mode = int'(mode);
        end
        if (paletteWe) pal[paletteIndex] = paletteData;
        if (exp_q.size() != 0) {exp_act, exp_hs, exp_vs, exp_pix} = exp_q.pop_front();
    endtask

    // Driver: one clock of the randomized main phase with full output checking.
    task automatic tick_main();
        int en, pos;
        logic fs_exp, li_exp;
        @(posedge clock);
        #1;
        model_step();
        check_eq("pixel", videoOutput, exp_pix);
        check_eq("active", videoActive, exp_act);
        check_eq("hsync", hSync, exp_hs);
        check_eq("vsync", vSync, exp_vs);
        check_eq("underflow_idle", underflow, 1'b0);

        cyc++;
        paletteWe    = ($urandom_range(0, 19) == 0);
        paletteIndex = 4'($urandom_range(0, 15));
        paletteData  = 8'($urandom_range(0, 255));
        if (cyc == next_mode_at) begin
            mode = mode + 2'd1;
            next_mode_at = cyc + $urandom_range(100, 300);
        end
        if (cyc == next_lc_at) begin
            lineCompare = 10'($urandom_range(0, VT + 2));
            next_lc_at = cyc + $urandom_range(200, 700);
        end
        #1;

        en     = edge_n + 1;
        pos    = (en / CD - 1) % FRAME;
        fs_exp = (en % CD == 0) && (pos == FRAME - 1);
`ifdef VIDEO_LINE_IRQ_EN
        li_exp = (en % CD == 0) && (pos % HT == HT - 1) && (((pos / HT + 1) % VT) == int'(lineCompare));
`else
        li_exp = 1'b0;
`endif
        check_eq("frame_start", frameStart, fs_exp);
        check_eq("line_irq", lineIrq, li_exp);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pixel"}, videoOutput, 8'h00);
        check_eq({tag, "_active"}, videoActive, 1'b0);
        check_eq({tag, "_hsync"}, hSync, 1'b1);
        check_eq({tag, "_vsync"}, vSync, 1'b1);
        check_eq({tag, "_frame_start"}, frameStart, 1'b0);
        check_eq({tag, "_line_irq"}, lineIrq, 1'b0);
        check_eq({tag, "_underflow"}, underflow, 1'b0);
    endtask

    task automatic tick_n(input int n, inout int ue);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            ue++;
        end
    endtask

    initial begin
        int   ue;
        logic found;
        reset          = 1'b1;
        mode           = 2'd0;
        videoDataReady = 1'b1;
        paletteWe      = 1'b0;
        paletteIndex   = 4'd0;
        paletteData    = 8'd0;
        underflowClear = 1'b0;
        lineCompare    = 10'd5;
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom_range(0, 255));
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");

        // Main phase: random frame buffer, palette writes, mode and lineCompare changes.
        @(negedge clock);
        reset        = 1'b0;
        cyc          = 0;
        next_mode_at = 120;
        next_lc_at   = 300;
        for (int c = 0; c < 5 * FRAME * CD; c++) tick_main();

        // Reset asserted in the middle of a visible line.
        found = 1'b0;
        for (int c = 0; c < 4 * HT * CD && !found; c++) begin
            tick_main();
            if (exp_act) found = 1'b1;
        end
        check_eq("midline_wait", found, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midline_reset");

        // Underflow phase: no data ever ready, direct mode.
        videoDataReady = 1'b0;
        mode           = 2'd0;
        paletteWe      = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        ue = 0;
        tick_n(2, ue);
        check_eq("uf_first", underflow, 1'b1);
        check_eq("uf_active", videoActive, 1'b1);
        check_eq("uf_stale", videoOutput, 8'h00);
        tick_n(32, ue);
        check_eq("uf_sticky", underflow, 1'b1);
        underflowClear = 1'b1;
        tick_n(1, ue);
        underflowClear = 1'b0;
        check_eq("uf_clear", underflow, 1'b0);
        tick_n(14, ue);
        check_eq("uf_blank_hold", underflow, 1'b0);
        tick_n(1, ue);
        check_eq("uf_reset_on_miss", underflow, 1'b1);
        underflowClear = 1'b1;
        tick_n(1, ue);
        check_eq("uf_clear2", underflow, 1'b0);
        tick_n(1, ue);
        check_eq("uf_set_wins", underflow, 1'b1);
        videoDataReady = 1'b1;
        tick_n(1, ue);
        underflowClear = 1'b0;
        check_eq("uf_cleared_ready", underflow, 1'b0);
        tick_n(1, ue);
        check_eq("uf_recover", underflow, 1'b0);
        check_eq("uf_data", videoOutput, model_pixel(2, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
